// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the instruction control sequencer.
// MUL_DIV_EN adds the T6 state used by multiply/divide write-back.
package control_sequencer_pkg;

    localparam int unsigned IR_W       = 32;
    localparam int unsigned OPCODE_W   = 5;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned ALU_OP_W   = 4;
    localparam int unsigned BUS_SEL_W  = 5;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
`ifdef MUL_DIV_EN
        ST_T6     = 4'd7,
`endif
        ST_HALTED = 4'd8,
        ST_FAULT  = 4'd9
    } state_t;

    // Instruction register field layout
    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [REG_ADDR_W-1:0] ra;
        logic [REG_ADDR_W-1:0] rb;
        logic [REG_ADDR_W-1:0] rc;
        logic [14:0]           rsvd;
    } ir_t;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b01111;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b10000;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11011;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_ROR = 4'b1010;
    localparam logic [ALU_OP_W-1:0] ALU_MUL = 4'b1101;
    localparam logic [ALU_OP_W-1:0] ALU_DIV = 4'b1110;

    // Bus sources beyond the 16 general-purpose registers
    localparam logic [BUS_SEL_W-1:0] SEL_HI  = 5'd16;
    localparam logic [BUS_SEL_W-1:0] SEL_LO  = 5'd17;
    localparam logic [BUS_SEL_W-1:0] SEL_ZHI = 5'd18;
    localparam logic [BUS_SEL_W-1:0] SEL_ZLO = 5'd19;
    localparam logic [BUS_SEL_W-1:0] SEL_PC  = 5'd20;
    localparam logic [BUS_SEL_W-1:0] SEL_MDR = 5'd21;

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode legality check and ALU operation mapping.
// MUL/DIV are legal only when MUL_DIV_EN is defined.
module opcode_decoder
    import control_sequencer_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output logic [ALU_OP_W-1:0] alu_op_c,
    output logic                legal_c,
    output logic                halt_c,
    output logic                muldiv_c
);

    assign halt_c = (opcode == OP_HALT);

    always_comb begin
        alu_op_c = '0;
        legal_c  = 1'b0;
        muldiv_c = 1'b0;
        case (opcode)
            OP_ADD: begin alu_op_c = ALU_ADD; legal_c = 1'b1; end
            OP_SUB: begin alu_op_c = ALU_SUB; legal_c = 1'b1; end
            OP_AND: begin alu_op_c = ALU_AND; legal_c = 1'b1; end
            OP_OR:  begin alu_op_c = ALU_OR;  legal_c = 1'b1; end
            OP_ROR: begin alu_op_c = ALU_ROR; legal_c = 1'b1; end
`ifdef MUL_DIV_EN
            OP_MUL: begin alu_op_c = ALU_MUL; legal_c = 1'b1; muldiv_c = 1'b1; end
            OP_DIV: begin alu_op_c = ALU_DIV; legal_c = 1'b1; muldiv_c = 1'b1; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2), decode/execute (T3-T5/T6), halt and fault traps.
// Defining MUL_DIV_EN enables MUL/DIV with the extra HI write-back state T6.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  run,
    input  logic                  mem_ready,
    input  logic [IR_W-1:0]       IR,
    output logic [BUS_SEL_W-1:0]  BusDataSelect,
    output logic [REG_ADDR_W-1:0] GP_addr,
    output logic                  e_PC,
    output logic                  e_IR,
    output logic                  e_Y,
    output logic                  e_Z,
    output logic                  e_HI,
    output logic                  e_LO,
    output logic                  e_MDR,
    output logic                  e_MAR,
    output logic                  e_GP,
    output logic                  incPC,
    output logic                  MDR_read,
    output logic [ALU_OP_W-1:0]   ALU_op,
    output logic                  busy,
    output logic                  fault
);

    state_t              state;
    state_t              state_next;
    logic                pc_loaded;
    ir_t                 ir;
    logic [ALU_OP_W-1:0] alu_op_c;
    logic                legal_c;
    logic                halt_c;
    logic                muldiv_c;
    logic                unused_rsvd;

    assign ir          = ir_t'(IR);
    assign unused_rsvd = ^ir.rsvd;

    opcode_decoder u_decoder (
        .opcode   (ir.opcode),
        .alu_op_c (alu_op_c),
        .legal_c  (legal_c),
        .halt_c   (halt_c),
        .muldiv_c (muldiv_c)
    );

    // pc_loaded marks T1 stall cycles so PC is written only on the first one
    always_ff @(posedge clock) begin
        if (!clear) begin
            state     <= ST_IDLE;
            pc_loaded <= 1'b0;
        end else begin
            state     <= state_next;
            pc_loaded <= (state == ST_T1) && !mem_ready;
        end
    end

    always_comb begin
        state_next    = state;
        BusDataSelect = '0;
        GP_addr       = '0;
        ALU_op        = '0;
        e_PC          = 1'b0;
        e_IR          = 1'b0;
        e_Y           = 1'b0;
        e_Z           = 1'b0;
        e_HI          = 1'b0;
        e_LO          = 1'b0;
        e_MDR         = 1'b0;
        e_MAR         = 1'b0;
        e_GP          = 1'b0;
        incPC         = 1'b0;
        MDR_read      = 1'b0;
        busy          = 1'b0;
        fault         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (run) state_next = ST_T0;
            end
            ST_T0: begin
                busy          = 1'b1;
                BusDataSelect = SEL_PC;
                e_MAR         = 1'b1;
                incPC         = 1'b1;
                e_Z           = 1'b1;
                state_next    = ST_T1;
            end
            ST_T1: begin
                busy          = 1'b1;
                BusDataSelect = SEL_ZLO;
                e_PC          = !pc_loaded;
                MDR_read      = 1'b1;
                e_MDR         = 1'b1;
                if (mem_ready) state_next = ST_T2;
            end
            ST_T2: begin
                busy          = 1'b1;
                BusDataSelect = SEL_MDR;
                e_IR          = 1'b1;
                state_next    = ST_T3;
            end
            ST_T3: begin
                busy = 1'b1;
                if (halt_c) begin
                    state_next = ST_HALTED;
                end else if (!legal_c) begin
                    state_next = ST_FAULT;
                end else begin
                    BusDataSelect = BUS_SEL_W'(ir.rb);
                    e_Y           = 1'b1;
                    state_next    = ST_T4;
                end
            end
            ST_T4: begin
                busy          = 1'b1;
                BusDataSelect = BUS_SEL_W'(ir.rc);
                ALU_op        = alu_op_c;
                e_Z           = 1'b1;
                state_next    = ST_T5;
            end
            ST_T5: begin
                busy          = 1'b1;
                BusDataSelect = SEL_ZLO;
                state_next    = run ? ST_T0 : ST_IDLE;
                if (muldiv_c) begin
                    e_LO = 1'b1;
`ifdef MUL_DIV_EN
                    state_next = ST_T6;
`endif
                end else begin
                    GP_addr = ir.ra;
                    e_GP    = 1'b1;
                end
            end
`ifdef MUL_DIV_EN
            ST_T6: begin
                busy          = 1'b1;
                BusDataSelect = SEL_ZHI;
                e_HI          = 1'b1;
                state_next    = run ? ST_T0 : ST_IDLE;
            end
`endif
            ST_HALTED: ;
            ST_FAULT: begin
                fault = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer; MUL/DIV expectations follow MUL_DIV_EN.
module tb_control_sequencer;

    logic        clock;
    logic        clear;
    logic        run;
    logic        mem_ready;
    logic [31:0] IR;
    logic [4:0]  BusDataSelect;
    logic [3:0]  GP_addr;
    logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, incPC, MDR_read;
    logic [3:0]  ALU_op;
    logic        busy;
    logic        fault;

    int errors = 0;
    int checks = 0;

    // Strobe mask bit order: e_PC e_IR e_Y e_Z e_HI e_LO e_MDR e_MAR e_GP incPC MDR_read
    localparam logic [10:0] S_PC  = 11'h400;
    localparam logic [10:0] S_IR  = 11'h200;
    localparam logic [10:0] S_Y   = 11'h100;
    localparam logic [10:0] S_Z   = 11'h080;
    localparam logic [10:0] S_HI  = 11'h040;
    localparam logic [10:0] S_LO  = 11'h020;
    localparam logic [10:0] S_MDR = 11'h010;
    localparam logic [10:0] S_MAR = 11'h008;
    localparam logic [10:0] S_GP  = 11'h004;
    localparam logic [10:0] S_INC = 11'h002;
    localparam logic [10:0] S_MRD = 11'h001;

    // Word layout: {BusDataSelect, GP_addr, ALU_op, strobes, busy, fault}
    localparam logic [25:0] W_IDLE  = 26'd0;
    localparam logic [25:0] W_T0    = {5'd20, 8'd0, S_MAR | S_INC | S_Z, 2'b10};
    localparam logic [25:0] W_T1    = {5'd19, 8'd0, S_PC | S_MDR | S_MRD, 2'b10};
    localparam logic [25:0] W_T1S   = {5'd19, 8'd0, S_MDR | S_MRD, 2'b10};
    localparam logic [25:0] W_T2    = {5'd21, 8'd0, S_IR, 2'b10};
    localparam logic [25:0] W_T3X   = {5'd0, 8'd0, 11'd0, 2'b10};
    localparam logic [25:0] W_FAULT = {5'd0, 8'd0, 11'd0, 2'b01};

    localparam logic [31:0] IR_ROR  = 32'h2A328000;
    localparam logic [31:0] IR_ADD  = 32'h00918000;
    localparam logic [31:0] IR_BAD  = 32'hF8000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;

    control_sequencer dut (
        .clock         (clock),
        .clear         (clear),
        .run           (run),
        .mem_ready     (mem_ready),
        .IR            (IR),
        .BusDataSelect (BusDataSelect),
        .GP_addr       (GP_addr),
        .e_PC          (e_PC),
        .e_IR          (e_IR),
        .e_Y           (e_Y),
        .e_Z           (e_Z),
        .e_HI          (e_HI),
        .e_LO          (e_LO),
        .e_MDR         (e_MDR),
        .e_MAR         (e_MAR),
        .e_GP          (e_GP),
        .incPC         (incPC),
        .MDR_read      (MDR_read),
        .ALU_op        (ALU_op),
        .busy          (busy),
        .fault         (fault)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [25:0] obs();
        return {BusDataSelect, GP_addr, ALU_op, e_PC, e_IR, e_Y, e_Z, e_HI, e_LO,
                e_MDR, e_MAR, e_GP, incPC, MDR_read, busy, fault};
    endfunction

    function automatic logic [25:0] mk(input logic [4:0] bds, input logic [3:0] gp,
                                       input logic [3:0] alu, input logic [10:0] stb,
                                       input logic b, input logic f);
        return {bds, gp, alu, stb, b, f};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0; run = 1'b0; mem_ready = 1'b1; IR = 32'd0;
        tick(); tick();
        checks++; if (obs() !== W_IDLE) begin errors++; $display("FAIL reset_idle: got %h expected %h", obs(), W_IDLE); end
        run = 1'b1;
        tick();
        checks++; if (obs() !== W_IDLE) begin errors++; $display("FAIL reset_dominates_run: got %h expected %h", obs(), W_IDLE); end
        clear = 1'b1; run = 1'b0;
        tick();
        checks++; if (obs() !== W_IDLE) begin errors++; $display("FAIL idle_hold: got %h expected %h", obs(), W_IDLE); end
    endtask

    task automatic test_ror();
        IR = IR_ROR; run = 1'b1; mem_ready = 1'b1;
        tick();
        checks++; if (obs() !== W_T0) begin errors++; $display("FAIL ror_t0: got %h expected %h", obs(), W_T0); end
        tick();
        checks++; if (obs() !== W_T1) begin errors++; $display("FAIL ror_t1: got %h expected %h", obs(), W_T1); end
        tick();
        checks++; if (obs() !== W_T2) begin errors++; $display("FAIL ror_t2: got %h expected %h", obs(), W_T2); end
        tick();
        checks++; if (obs() !== mk(5'd6, 4'd0, 4'd0, S_Y, 1'b1, 1'b0)) begin errors++; $display("FAIL ror_t3: got %h expected %h", obs(), mk(5'd6, 4'd0, 4'd0, S_Y, 1'b1, 1'b0)); end
        tick();
        checks++; if (obs() !== mk(5'd5, 4'd0, 4'b1010, S_Z, 1'b1, 1'b0)) begin errors++; $display("FAIL ror_t4: got %h expected %h", obs(), mk(5'd5, 4'd0, 4'b1010, S_Z, 1'b1, 1'b0)); end
        tick();
        checks++; if (obs() !== mk(5'd19, 4'd4, 4'd0, S_GP, 1'b1, 1'b0)) begin errors++; $display("FAIL ror_t5: got %h expected %h", obs(), mk(5'd19, 4'd4, 4'd0, S_GP, 1'b1, 1'b0)); end
        tick();
        checks++; if (obs() !== W_T0) begin errors++; $display("FAIL ror_next_t0: got %h expected %h", obs(), W_T0); end
        clear = 1'b0;
        tick();
        checks++; if (obs() !== W_IDLE) begin errors++; $display("FAIL clear_in_t0: got %h expected %h", obs(), W_IDLE); end
        clear = 1'b1; run = 1'b0;
    endtask

    task automatic test_stall();
        IR = IR_ADD; run = 1'b1; mem_ready = 1'b0;
        tick();
        checks++; if (obs() !== W_T0) begin errors++; $display("FAIL stall_t0: got %h expected %h", obs(), W_T0); end
        tick();
        checks++; if (obs() !== W_T1) begin errors++; $display("FAIL stall_t1_first: got %h expected %h", obs(), W_T1); end
        for (int c = 2; c <= 4; c++) begin
            tick();
            checks++; if (obs() !== W_T1S) begin errors++; $display("FAIL stall_t1_cycle%0d: got %h expected %h", c, obs(), W_T1S); end
        end
        mem_ready = 1'b1; run = 1'b0;
        tick();
        checks++; if (obs() !== W_T2) begin errors++; $display("FAIL stall_t2: got %h expected %h", obs(), W_T2); end
        tick();
        checks++; if (obs() !== mk(5'd2, 4'd0, 4'd0, S_Y, 1'b1, 1'b0)) begin errors++; $display("FAIL add_t3: got %h expected %h", obs(), mk(5'd2, 4'd0, 4'd0, S_Y, 1'b1, 1'b0)); end
        tick();
        checks++; if (obs() !== mk(5'd3, 4'd0, 4'd0, S_Z, 1'b1, 1'b0)) begin errors++; $display("FAIL add_t4: got %h expected %h", obs(), mk(5'd3, 4'd0, 4'd0, S_Z, 1'b1, 1'b0)); end
        tick();
        checks++; if (obs() !== mk(5'd19, 4'd1, 4'd0, S_GP, 1'b1, 1'b0)) begin errors++; $display("FAIL add_t5: got %h expected %h", obs(), mk(5'd19, 4'd1, 4'd0, S_GP, 1'b1, 1'b0)); end
        tick();
        checks++; if (obs() !== W_IDLE) begin errors++; $display("FAIL add_to_idle: got %h expected %h", obs(), W_IDLE); end
    endtask

    task automatic test_run_drop();
        IR = IR_ROR; run = 1'b1; mem_ready = 1'b1;
        tick(); tick(); tick();
        checks++; if (obs() !== W_T2) begin errors++; $display("FAIL drop_t2: got %h expected %h", obs(), W_T2); end
        run = 1'b0;
        tick();
        checks++; if (obs() !== mk(5'd6, 4'd0, 4'd0, S_Y, 1'b1, 1'b0)) begin errors++; $display("FAIL drop_t3: got %h expected %h", obs(), mk(5'd6, 4'd0, 4'd0, S_Y, 1'b1, 1'b0)); end
        tick(); tick();
        checks++; if (obs() !== mk(5'd19, 4'd4, 4'd0, S_GP, 1'b1, 1'b0)) begin errors++; $display("FAIL drop_t5: got %h expected %h", obs(), mk(5'd19, 4'd4, 4'd0, S_GP, 1'b1, 1'b0)); end
        tick();
        checks++; if (obs() !== W_IDLE) begin errors++; $display("FAIL drop_idle: got %h expected %h", obs(), W_IDLE); end
        tick();
        checks++; if (obs() !== W_IDLE) begin errors++; $display("FAIL drop_no_t0: got %h expected %h", obs(), W_IDLE); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] ops [4] = '{5'b00000, 5'b00001, 5'b00010, 5'b00011};
        logic [3:0] alus [4] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011};
        run = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            IR = {ops[i], 4'(i + 1), 4'd7, 4'd8, 15'd0};
            tick();
            checks++; if (obs() !== W_T0) begin errors++; $display("FAIL b2b_t0_%0d: got %h expected %h", i, obs(), W_T0); end
            tick(); tick(); tick(); tick();
            checks++; if (obs() !== mk(5'd8, 4'd0, alus[i], S_Z, 1'b1, 1'b0)) begin errors++; $display("FAIL b2b_t4_%0d: got %h expected %h", i, obs(), mk(5'd8, 4'd0, alus[i], S_Z, 1'b1, 1'b0)); end
            tick();
            checks++; if (obs() !== mk(5'd19, 4'(i + 1), 4'd0, S_GP, 1'b1, 1'b0)) begin errors++; $display("FAIL b2b_t5_%0d: got %h expected %h", i, obs(), mk(5'd19, 4'(i + 1), 4'd0, S_GP, 1'b1, 1'b0)); end
        end
        run = 1'b0;
        tick();
        checks++; if (obs() !== W_IDLE) begin errors++; $display("FAIL b2b_idle: got %h expected %h", obs(), W_IDLE); end
    endtask

    task automatic test_fault();
        IR = IR_BAD; run = 1'b1; mem_ready = 1'b1;
        tick(); tick(); tick(); tick();
        checks++; if (obs() !== W_T3X) begin errors++; $display("FAIL fault_t3: got %h expected %h", obs(), W_T3X); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (obs() !== W_FAULT) begin errors++; $display("FAIL fault_hold%0d: got %h expected %h", c, obs(), W_FAULT); end
        end
        clear = 1'b0;
        tick();
        checks++; if (obs() !== W_IDLE) begin errors++; $display("FAIL fault_clear: got %h expected %h", obs(), W_IDLE); end
        clear = 1'b1; run = 1'b0;
    endtask

    task automatic test_halt();
        IR = IR_HALT; run = 1'b1; mem_ready = 1'b1;
        tick(); tick(); tick(); tick();
        checks++; if (obs() !== W_T3X) begin errors++; $display("FAIL halt_t3: got %h expected %h", obs(), W_T3X); end
        tick(); tick();
        checks++; if (obs() !== W_IDLE) begin errors++; $display("FAIL halt_hold: got %h expected %h", obs(), W_IDLE); end
        clear = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        checks++; if (obs() !== W_T0) begin errors++; $display("FAIL halt_restart: got %h expected %h", obs(), W_T0); end
        clear = 1'b0;
        tick();
        clear = 1'b1; run = 1'b0;
    endtask

    task automatic test_muldiv();
        logic [4:0] ops [2] = '{5'b01111, 5'b10000};
        logic [3:0] alus [2] = '{4'b1101, 4'b1110};
        mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            IR = {ops[i], 27'h0918000}; run = 1'b1;
            tick(); tick(); tick();
            run = 1'b0;
            tick();
`ifdef MUL_DIV_EN
            checks++; if (obs() !== mk(5'd2, 4'd0, 4'd0, S_Y, 1'b1, 1'b0)) begin errors++; $display("FAIL md_t3_%0d: got %h expected %h", i, obs(), mk(5'd2, 4'd0, 4'd0, S_Y, 1'b1, 1'b0)); end
            tick();
            checks++; if (obs() !== mk(5'd3, 4'd0, alus[i], S_Z, 1'b1, 1'b0)) begin errors++; $display("FAIL md_t4_%0d: got %h expected %h", i, obs(), mk(5'd3, 4'd0, alus[i], S_Z, 1'b1, 1'b0)); end
            tick();
            checks++; if (obs() !== mk(5'd19, 4'd0, 4'd0, S_LO, 1'b1, 1'b0)) begin errors++; $display("FAIL md_t5_%0d: got %h expected %h", i, obs(), mk(5'd19, 4'd0, 4'd0, S_LO, 1'b1, 1'b0)); end
            tick();
            checks++; if (obs() !== mk(5'd18, 4'd0, 4'd0, S_HI, 1'b1, 1'b0)) begin errors++; $display("FAIL md_t6_%0d: got %h expected %h", i, obs(), mk(5'd18, 4'd0, 4'd0, S_HI, 1'b1, 1'b0)); end
            tick();
            checks++; if (obs() !== W_IDLE) begin errors++; $display("FAIL md_idle_%0d: got %h expected %h", i, obs(), W_IDLE); end
`else
            checks++; if (obs() !== W_T3X) begin errors++; $display("FAIL md_t3_%0d: got %h expected %h alu %h", i, obs(), W_T3X, alus[i]); end
            tick();
            checks++; if (obs() !== W_FAULT) begin errors++; $display("FAIL md_fault_%0d: got %h expected %h", i, obs(), W_FAULT); end
            clear = 1'b0;
            tick();
            clear = 1'b1;
`endif
        end
    endtask

    task automatic test_clear_t4();
        IR = IR_ROR; run = 1'b1; mem_ready = 1'b1;
        tick(); tick(); tick(); tick(); tick();
        checks++; if (obs() !== mk(5'd5, 4'd0, 4'b1010, S_Z, 1'b1, 1'b0)) begin errors++; $display("FAIL clr4_t4: got %h expected %h", obs(), mk(5'd5, 4'd0, 4'b1010, S_Z, 1'b1, 1'b0)); end
        clear = 1'b0;
        tick();
        checks++; if (obs() !== W_IDLE) begin errors++; $display("FAIL clr4_idle: got %h expected %h", obs(), W_IDLE); end
        clear = 1'b1; run = 1'b0;
        tick();
        checks++; if (obs() !== W_IDLE) begin errors++; $display("FAIL clr4_stay: got %h expected %h", obs(), W_IDLE); end
    endtask

    task automatic test_clear_stall();
        IR = IR_ADD; run = 1'b1; mem_ready = 1'b0;
        tick(); tick(); tick();
        checks++; if (obs() !== W_T1S) begin errors++; $display("FAIL clrst_stall: got %h expected %h", obs(), W_T1S); end
        clear = 1'b0;
        tick();
        checks++; if (obs() !== W_IDLE) begin errors++; $display("FAIL clrst_idle: got %h expected %h", obs(), W_IDLE); end
        clear = 1'b1; mem_ready = 1'b1;
        tick(); tick();
        checks++; if (obs() !== W_T1) begin errors++; $display("FAIL clrst_refetch_t1: got %h expected %h", obs(), W_T1); end
        clear = 1'b0;
        tick();
        clear = 1'b1; run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ror();
        test_stall();
        test_run_drop();
        test_back_to_back();
        test_fault();
        test_halt();
        test_muldiv();
        test_clear_t4();
        test_clear_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
